// File: rtl/arm7_regfile.sv
// arm7_regfile: 16-entry ARM7 register bank, two client ports, one-entry pending buffer for port 1 write conflicts.
// Optional REGFILE_BYPASS_EN forwards the value committing at an edge to same-edge reads.
module arm7_regfile #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] PC_STEP = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en_0,
  input  logic [3:0]        read_reg_0,
  output logic [DATA_W-1:0] read_value_0,
  input  logic              write_en_0,
  input  logic [3:0]        write_reg_0,
  input  logic [DATA_W-1:0] write_value_0,
  input  logic              read_en_1,
  input  logic [3:0]        read_reg_1,
  output logic [DATA_W-1:0] read_value_1,
  input  logic              write_en_1,
  input  logic [3:0]        write_reg_1,
  input  logic [DATA_W-1:0] write_value_1,
  output logic              wr_stall_1,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc_value
);
  logic [15:0][DATA_W-1:0] regs, nxt;
  logic                    pend_v;
  logic [3:0]              pend_reg;
  logic [DATA_W-1:0]       pend_val;
  logic                    c_en, pc_eff, cap;
  logic [3:0]              c_reg;
  logic [DATA_W-1:0]       c_val, src_0, src_1;
  // at most one register write commits per edge: port 0, else pending, else port 1
  assign c_en   = write_en_0 | pend_v | write_en_1;
  assign c_reg  = write_en_0 ? write_reg_0 : pend_v ? pend_reg : write_reg_1;
  assign c_val  = write_en_0 ? write_value_0 : pend_v ? pend_val : write_value_1;
  assign pc_eff = pc_inc & ~(c_en & (c_reg == 4'd15));
  assign cap    = write_en_0 & write_en_1 & ~pend_v;
  assign wr_stall_1 = pend_v;
  assign pc_value   = regs[15];
  always_comb begin
    nxt = regs;
    if (c_en) nxt[c_reg] = c_val;
    if (pc_eff) nxt[15] = regs[15] + PC_STEP;
  end
`ifdef REGFILE_BYPASS_EN
  assign src_0 = nxt[read_reg_0];
  assign src_1 = nxt[read_reg_1];
`else
  assign src_0 = regs[read_reg_0];
  assign src_1 = regs[read_reg_1];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
      regs[15]     <= PC_RESET;
      read_value_0 <= '0;
      read_value_1 <= '0;
      pend_v       <= 1'b0;
      pend_reg     <= '0;
      pend_val     <= '0;
    end else begin
      regs <= nxt;
      if (read_en_0) read_value_0 <= src_0;
      if (read_en_1) read_value_1 <= src_1;
      if (cap) begin
        pend_v   <= 1'b1;
        pend_reg <= write_reg_1;
        pend_val <= write_value_1;
      end else if (pend_v && !write_en_0) begin
        pend_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arm7_regfile.sv
// tb_arm7_regfile: directed-vector bench for arm7_regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_arm7_regfile;
  localparam logic [31:0] PCR = 32'h0000_0040;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        read_en_0 = 0, read_en_1 = 0, write_en_0 = 0, write_en_1 = 0, pc_inc = 0;
  logic [3:0]  read_reg_0 = 0, read_reg_1 = 0, write_reg_0 = 0, write_reg_1 = 0;
  logic [31:0] write_value_0 = 0, write_value_1 = 0;
  logic [31:0] read_value_0, read_value_1, pc_value;
  logic        wr_stall_1;
  int nvec = 0, nerr = 0;

  arm7_regfile #(.DATA_W(32), .PC_RESET(PCR), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_en_0(read_en_0), .read_reg_0(read_reg_0), .read_value_0(read_value_0),
    .write_en_0(write_en_0), .write_reg_0(write_reg_0), .write_value_0(write_value_0),
    .read_en_1(read_en_1), .read_reg_1(read_reg_1), .read_value_1(read_value_1),
    .write_en_1(write_en_1), .write_reg_1(write_reg_1), .write_value_1(write_value_1),
    .wr_stall_1(wr_stall_1), .pc_inc(pc_inc), .pc_value(pc_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en_0 = 0; read_en_1 = 0; write_en_0 = 0; write_en_1 = 0; pc_inc = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL rst_stall got %h exp 0", wr_stall_1); end
    nvec++; if (read_value_0 !== 32'h0) begin nerr++; $display("FAIL rst_rv0 got %h exp 0", read_value_0); end
    nvec++; if (pc_value !== PCR) begin nerr++; $display("FAIL rst_pc got %h exp %h", pc_value, PCR); end
    tick();
    rst_n = 1;
    read_en_0 = 1; read_reg_0 = 4'd15; read_en_1 = 1; read_reg_1 = 4'd3;
    tick();
    nvec++; if (read_value_0 !== PCR) begin nerr++; $display("FAIL rst_read_r15 got %h exp %h", read_value_0, PCR); end
    nvec++; if (read_value_1 !== 32'h0) begin nerr++; $display("FAIL rst_read_r3 got %h exp 0", read_value_1); end
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL rst_stall_after got %h exp 0", wr_stall_1); end
    idle();
  endtask

  task automatic test_write_read();
    write_en_0 = 1; write_reg_0 = 4'd3; write_value_0 = 32'hDEAD_BEEF;
    tick();
    write_en_0 = 0;
    read_en_0 = 1; read_reg_0 = 4'd3; read_en_1 = 1; read_reg_1 = 4'd3;
    tick();
    nvec++; if (read_value_0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL wr_rd_p0 got %h exp deadbeef", read_value_0); end
    nvec++; if (read_value_1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL wr_rd_p1 got %h exp deadbeef", read_value_1); end
    idle();
    write_en_0 = 1; write_reg_0 = 4'd3; write_value_0 = 32'h1111_1111;
    tick();
    write_en_0 = 0;
    for (int i = 0; i < 4; i++) tick();
    nvec++; if (read_value_0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL hold_p0 got %h exp deadbeef", read_value_0); end
    nvec++; if (read_value_1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL hold_p1 got %h exp deadbeef", read_value_1); end
  endtask

  task automatic test_conflict();
    write_en_0 = 1; write_reg_0 = 4'd5; write_value_0 = 32'd1;
    write_en_1 = 1; write_reg_1 = 4'd5; write_value_1 = 32'd2;
    tick();
    nvec++; if (wr_stall_1 !== 1'b1) begin nerr++; $display("FAIL cf_stall_set got %h exp 1", wr_stall_1); end
    idle();
    read_en_0 = 1; read_reg_0 = 4'd5;
    tick();
`ifdef REGFILE_BYPASS_EN
    nvec++; if (read_value_0 !== 32'd2) begin nerr++; $display("FAIL cf_r5_first got %h exp 2", read_value_0); end
`else
    nvec++; if (read_value_0 !== 32'd1) begin nerr++; $display("FAIL cf_r5_first got %h exp 1", read_value_0); end
`endif
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL cf_stall_clr got %h exp 0", wr_stall_1); end
    tick();
    nvec++; if (read_value_0 !== 32'd2) begin nerr++; $display("FAIL cf_r5_retired got %h exp 2", read_value_0); end
    idle();
    write_en_0 = 1; write_reg_0 = 4'd6; write_value_0 = 32'd7;
    write_en_1 = 1; write_reg_1 = 4'd6; write_value_1 = 32'd8;
    tick();
    write_reg_0 = 4'd9; write_value_0 = 32'd3;
    write_reg_1 = 4'd6; write_value_1 = 32'h55;
    tick();
    nvec++; if (wr_stall_1 !== 1'b1) begin nerr++; $display("FAIL cf_stall_ext got %h exp 1", wr_stall_1); end
    idle();
    tick();
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL cf_stall_ext_clr got %h exp 0", wr_stall_1); end
    read_en_0 = 1; read_reg_0 = 4'd6; read_en_1 = 1; read_reg_1 = 4'd9;
    tick();
    tick();
    nvec++; if (read_value_0 !== 32'd8) begin nerr++; $display("FAIL cf_r6 got %h exp 8", read_value_0); end
    nvec++; if (read_value_1 !== 32'd3) begin nerr++; $display("FAIL cf_r9 got %h exp 3", read_value_1); end
    idle();
  endtask

  task automatic test_pc();
    write_en_0 = 1; write_reg_0 = 4'd15; write_value_0 = 32'h0;
    tick();
    write_en_0 = 0;
    nvec++; if (pc_value !== 32'h0) begin nerr++; $display("FAIL pc_load0 got %h exp 0", pc_value); end
    pc_inc = 1;
    tick();
    nvec++; if (pc_value !== 32'd4) begin nerr++; $display("FAIL pc_inc1 got %h exp 4", pc_value); end
    tick();
    nvec++; if (pc_value !== 32'd8) begin nerr++; $display("FAIL pc_inc2 got %h exp 8", pc_value); end
    tick();
    nvec++; if (pc_value !== 32'd12) begin nerr++; $display("FAIL pc_inc3 got %h exp c", pc_value); end
    write_en_0 = 1; write_reg_0 = 4'd15; write_value_0 = 32'h100;
    tick();
    nvec++; if (pc_value !== 32'h100) begin nerr++; $display("FAIL pc_write_wins got %h exp 100", pc_value); end
    write_value_0 = 32'hFFFF_FFFC;
    tick();
    write_en_0 = 0;
    tick();
    nvec++; if (pc_value !== 32'h0) begin nerr++; $display("FAIL pc_wrap got %h exp 0", pc_value); end
    idle();
  endtask

  task automatic test_bypass();
    write_en_0 = 1; write_reg_0 = 4'd7; write_value_0 = 32'd9;
    tick();
    write_value_0 = 32'd10;
    read_en_0 = 1; read_reg_0 = 4'd7;
    read_en_1 = 1; read_reg_1 = 4'd15; pc_inc = 1;
    tick();
`ifdef REGFILE_BYPASS_EN
    nvec++; if (read_value_0 !== 32'd10) begin nerr++; $display("FAIL byp_r7 got %h exp a", read_value_0); end
    nvec++; if (read_value_1 !== 32'd4) begin nerr++; $display("FAIL byp_pc got %h exp 4", read_value_1); end
`else
    nvec++; if (read_value_0 !== 32'd9) begin nerr++; $display("FAIL byp_r7 got %h exp 9", read_value_0); end
    nvec++; if (read_value_1 !== 32'd0) begin nerr++; $display("FAIL byp_pc got %h exp 0", read_value_1); end
`endif
    nvec++; if (pc_value !== 32'd4) begin nerr++; $display("FAIL byp_pc_after got %h exp 4", pc_value); end
    idle();
  endtask

  task automatic test_async_reset();
    write_en_0 = 1; write_reg_0 = 4'd2; write_value_0 = 32'hA;
    write_en_1 = 1; write_reg_1 = 4'd2; write_value_1 = 32'hB;
    tick();
    idle();
    nvec++; if (wr_stall_1 !== 1'b1) begin nerr++; $display("FAIL ar_stall_pre got %h exp 1", wr_stall_1); end
    #1 rst_n = 0;
    #1;
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL ar_stall got %h exp 0", wr_stall_1); end
    nvec++; if (read_value_0 !== 32'h0) begin nerr++; $display("FAIL ar_rv0 got %h exp 0", read_value_0); end
    nvec++; if (read_value_1 !== 32'h0) begin nerr++; $display("FAIL ar_rv1 got %h exp 0", read_value_1); end
    nvec++; if (pc_value !== PCR) begin nerr++; $display("FAIL ar_pc got %h exp %h", pc_value, PCR); end
    #1 rst_n = 1;
    tick();
    tick();
    read_en_0 = 1; read_reg_0 = 4'd2;
    tick();
    nvec++; if (read_value_0 !== 32'h0) begin nerr++; $display("FAIL ar_r2 got %h exp 0", read_value_0); end
    nvec++; if (wr_stall_1 !== 1'b0) begin nerr++; $display("FAIL ar_stall_post got %h exp 0", wr_stall_1); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_pc();
    test_bypass();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
